// File: rtl/fifo_burst_reader.sv
// Burst reader: pops len+1 words from a synchronous FIFO and forwards them on a
// valid/ready stream through a 2-entry skid buffer, flagging the last word.
module fifo_burst_reader #(
  parameter int DT_WIDTH  = 8,
  parameter int LEN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 f_empty,
  input  logic [DT_WIDTH-1:0]  rd_dt,
  output logic                 rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DT_WIDTH-1:0]  m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] CntOne = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] fetchCnt_q, fetchCnt_d;
  logic [1:0]           occ_q, occ_d;
  logic                 headPtr_q;
  logic [DT_WIDTH-1:0]  buf0Data_q, buf1Data_q;
  logic [1:0]           bufLast_q;
  logic                 done_q;

  logic push, pop, wrIdx, headLast, fetchIsLast;

  // A word may be fetched into a full buffer only when the head leaves that same edge.
  assign pop         = m_valid & m_ready;
  assign rd_en       = (state_q == FETCH) & ~f_empty & (~occ_q[1] | pop);
  assign push        = rd_en;
  assign fetchIsLast = (fetchCnt_q == len_q);
  assign wrIdx       = headPtr_q ^ occ_q[0];
  assign headLast    = headPtr_q ? bufLast_q[1] : bufLast_q[0];

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = headPtr_q ? buf1Data_q : buf0Data_q;
  assign m_last  = m_valid & headLast;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    fetchCnt_d = fetchCnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          len_d      = len;
          fetchCnt_d = '0;
        end
      end
      FETCH: begin
        if (rd_en) begin
          fetchCnt_d = fetchCnt_q + CntOne;
          if (fetchIsLast) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && headLast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      fetchCnt_q <= '0;
      occ_q      <= 2'd0;
      headPtr_q  <= 1'b0;
      buf0Data_q <= '0;
      buf1Data_q <= '0;
      bufLast_q  <= 2'b00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      fetchCnt_q <= fetchCnt_d;
      occ_q      <= occ_d;
      headPtr_q  <= headPtr_q ^ pop;
      done_q     <= pop & headLast;
      if (push) begin
        if (wrIdx) begin
          buf1Data_q   <= rd_dt;
          bufLast_q[1] <= fetchIsLast;
        end else begin
          buf0Data_q   <= rd_dt;
          bufLast_q[0] <= fetchIsLast;
        end
      end
    end
  end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DT_WIDTH, default 8, width of FIFO read data and output stream data.
REQ-002 SHALL have parameter LEN_WIDTH, default 4, width of the burst length field; a burst is len+1 words (1..2^LEN_WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-006 SHALL have port len  input  LEN_WIDTH  burst length minus one, sampled on an accepted start.
REQ-007 SHALL have port f_empty  input  1  FIFO empty flag from the synchronous FIFO.
REQ-008 SHALL have port rd_dt  input  DT_WIDTH  FIFO read data, valid in the same cycle as rd_en when f_empty=0.
REQ-009 SHALL have port rd_en  output  1  FIFO pop request.
REQ-010 SHALL have port m_valid  output  1  output stream word valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts the word.
REQ-012 SHALL have port m_data  output  DT_WIDTH  output stream word.
REQ-013 SHALL have port m_last  output  1  marks the final word of a burst, qualified by m_valid.
REQ-014 SHALL have port busy  output  1  high from accepted start until burst completion.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the final word of a burst is accepted downstream.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DRAIN.
REQ-017 IDLE: start=1 -> latch len, clear fetch and send counters, go to FETCH; busy=1 from the next cycle.
REQ-018 start SHALL be ignored while in FETCH or DRAIN.
REQ-019 rd_en SHALL be combinational: rd_en = (state==FETCH) & !f_empty & (occupancy<2 | output pop this cycle).
REQ-020 On every rising edge with rd_en=1, rd_dt SHALL be written into a 2-entry output buffer, with its last flag set when fetch count == latched len.
REQ-021 The fetch counter SHALL increment per rd_en; when the word with fetch count == len is fetched, FETCH -> DRAIN.
REQ-022 m_valid = buffer occupancy != 0; m_data/m_last SHALL come from the head entry, held stable while m_valid=1 and m_ready=0.
REQ-023 A transfer occurs when m_valid & m_ready; the head entry SHALL be popped that edge.
REQ-024 Simultaneous push and pop SHALL keep occupancy unchanged and preserve word order.
REQ-025 Occupancy SHALL never exceed 2; rd_en SHALL never be high while f_empty=1.
REQ-026 Transfer of an entry with last=1 SHALL pulse done for exactly one cycle (registered, the cycle after the transfer) and return FSM to IDLE.
REQ-027 DRAIN -> IDLE SHALL occur only on that transfer; busy SHALL fall in the same cycle done rises.
REQ-028 A start in the same cycle as done SHALL be accepted (FSM is IDLE that cycle).
REQ-029 len = 2^LEN_WIDTH-1 SHALL produce 2^LEN_WIDTH words without counter overflow corrupting the last flag.
REQ-030 f_empty mid-burst SHALL stall fetching without error; fetching resumes when f_empty=0.
REQ-031 m_ready low for any duration SHALL not drop or duplicate words.

Reset
REQ-032 rst=1 SHALL asynchronously force state IDLE, occupancy 0, counters 0, rd_en=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0.
REQ-033 Reset mid-burst SHALL discard buffered words; no resume after release.
REQ-034 First start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-035 FIFO holds 0x11,0x22,0x33; start, len=2, m_ready=1 -> rd_en high 3 cycles, m_data 0x11,0x22,0x33 in order, m_last only with 0x33, done one cycle after 0x33 transfer.
REQ-036 len=0, FIFO holds 0xA5 -> single word 0xA5 with m_last=1, busy 2-3 cycles, one done pulse.
REQ-037 len=3, m_ready=0 for 10 cycles -> exactly 2 rd_en pulses, m_data 1st word stable; m_ready=1 -> remaining 2 fetched, 4 words total, no loss.
REQ-038 len=15 (LEN_WIDTH=4), FIFO fed 1 word every 3 cycles -> rd_en never with f_empty=1, 16 words, m_last on 16th only.
REQ-039 rst asserted after 2 of 4 words sent -> all outputs 0 immediately; next start len=1 sends fresh 2 words.
REQ-040 start repeated during busy -> ignored; start in done cycle -> new burst begins next cycle.
